regwb_queue: RTL and testbench

Write-back queue that feeds the register file's write side (WA1/WD1/RegWrite general port and R0D/R0W dedicated R0 port). It accepts completed results from the execute stage through a valid/ready handshake and buffers up to DEPTH of them in order. It drains one entry per cycle into the register file and forwards still-pending values to the decode-stage read addresses, so reads never see stale data. It sits between EX and the register file, replacing the direct EX-to-register-file write path.

---
 rtl/regwb_queue.sv | 112 +++++++++++
 tb/tb_regwb_queue.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regwb_queue.sv
// Write-back queue between EX and the register file: buffers completed results in order,
// drains one per cycle into the write ports and forwards pending values to decode reads.
module regwb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    parameter int DW    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_wa,
    input  logic [DW-1:0]            in_wd,
    input  logic                     in_we,
    input  logic                     in_r0w,
    input  logic [DW-1:0]            in_r0d,
    input  logic                     wb_stall,
    output logic [AW-1:0]            WA1,
    output logic [DW-1:0]            WD1,
    output logic                     RegWrite,
    output logic                     R0W,
    output logic [DW-1:0]            R0D,
    input  logic [AW-1:0]            RA1,
    input  logic [AW-1:0]            RA2,
    output logic                     hit1,
    output logic                     hit2,
    output logic [DW-1:0]            byp1,
    output logic [DW-1:0]            byp2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] wa_q  [DEPTH];
    logic [DW-1:0] wd_q  [DEPTH];
    logic          we_q  [DEPTH];
    logic          r0w_q [DEPTH];
    logic [DW-1:0] r0d_q [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] slot;
    logic          nonempty;
    logic          enq;
    logic          drain;

    assign nonempty = (count != '0);
    assign in_ready = rst && (count < (PW+1)'(DEPTH));
    // Null results complete the handshake but never occupy a slot.
    assign enq      = in_valid && in_ready && (in_we || in_r0w);
    assign drain    = nonempty && !wb_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq)
                tail <= tail + 1'b1;
            if (drain)
                head <= head + 1'b1;
            count <= count + (PW+1)'(enq) - (PW+1)'(drain);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            wa_q[tail]  <= in_wa;
            wd_q[tail]  <= in_wd;
            we_q[tail]  <= in_we;
            r0w_q[tail] <= in_r0w;
            r0d_q[tail] <= in_r0d;
        end
    end

    assign WA1      = nonempty ? wa_q[head]  : '0;
    assign WD1      = nonempty ? wd_q[head]  : '0;
    assign R0D      = nonempty ? r0d_q[head] : '0;
    assign RegWrite = drain && we_q[head];
    assign R0W      = drain && r0w_q[head];

    // Walk oldest to youngest so the youngest match overrides; an R0 write beats a
    // general write to address 0 within the same entry.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        byp1 = '0;
        byp2 = '0;
        slot = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            slot = head + PW'(k);
            if ((PW+1)'(k) < count) begin
                if (RA1 == '0 && r0w_q[slot]) begin
                    hit1 = 1'b1;
                    byp1 = r0d_q[slot];
                end else if (we_q[slot] && wa_q[slot] == RA1) begin
                    hit1 = 1'b1;
                    byp1 = wd_q[slot];
                end
                if (RA2 == '0 && r0w_q[slot]) begin
                    hit2 = 1'b1;
                    byp2 = r0d_q[slot];
                end else if (we_q[slot] && wa_q[slot] == RA2) begin
                    hit2 = 1'b1;
                    byp2 = wd_q[slot];
                end
            end
        end
    end

endmodule

// File: tb/tb_regwb_queue.sv
// Directed bench for regwb_queue: register-file writes are checked against a scoreboard
// of accepted entries; bypass, occupancy and reset behaviour checked with constants.
module tb_regwb_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_wa;
    logic [15:0] in_wd;
    logic        in_we;
    logic        in_r0w;
    logic [15:0] in_r0d;
    logic        wb_stall;
    logic [3:0]  WA1;
    logic [15:0] WD1;
    logic        RegWrite;
    logic        R0W;
    logic [15:0] R0D;
    logic [3:0]  RA1;
    logic [3:0]  RA2;
    logic        hit1;
    logic        hit2;
    logic [15:0] byp1;
    logic [15:0] byp2;
    logic [2:0]  count;

    typedef struct packed {
        logic [3:0]  wa;
        logic [15:0] wd;
        logic        we;
        logic        r0w;
        logic [15:0] r0d;
    } ent_t;

    ent_t        sb[$];
    logic [15:0] rf [16];
    int          total;
    int          bad;

    regwb_queue #(.DEPTH(4), .AW(4), .DW(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wa(in_wa), .in_wd(in_wd), .in_we(in_we), .in_r0w(in_r0w), .in_r0d(in_r0d),
        .wb_stall(wb_stall),
        .WA1(WA1), .WD1(WD1), .RegWrite(RegWrite), .R0W(R0W), .R0D(R0D),
        .RA1(RA1), .RA2(RA2), .hit1(hit1), .hit2(hit2), .byp1(byp1), .byp2(byp2),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: at the falling edge, any strobe is a write the register file will take
    // on the next rising edge, so it is matched against the oldest expected entry.
    task automatic tick();
        ent_t e;
        @(negedge clk);
        if (RegWrite || R0W) begin
            if (sb.size() == 0) begin
                chk("unexp_wr", {30'd0, RegWrite, R0W}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wr_we",  {31'd0, RegWrite}, {31'd0, e.we});
                chk("wr_r0w", {31'd0, R0W},      {31'd0, e.r0w});
                chk("wr_wa",  {28'd0, WA1},      {28'd0, e.wa});
                chk("wr_wd",  {16'd0, WD1},      {16'd0, e.wd});
                chk("wr_r0d", {16'd0, R0D},      {16'd0, e.r0d});
            end
            if (RegWrite)
                rf[WA1] = WD1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] wa, input logic [15:0] wd, input logic we,
                        input logic r0w, input logic [15:0] r0d);
        ent_t e;
        in_valid = 1'b1;
        in_wa    = wa;
        in_wd    = wd;
        in_we    = we;
        in_r0w   = r0w;
        in_r0d   = r0d;
        chk("push_rdy", {31'd0, in_ready}, 32'd1);
        if (we || r0w) begin
            e.wa = wa; e.wd = wd; e.we = we; e.r0w = r0w; e.r0d = r0d;
            sb.push_back(e);
        end
        tick();
        in_valid = 1'b0;
        #1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_wa    = '0;
        in_wd    = '0;
        in_we    = 1'b0;
        in_r0w   = 1'b0;
        in_r0d   = '0;
        wb_stall = 1'b0;
        RA1      = '0;
        RA2      = '0;
        for (int i = 0; i < 16; i++) rf[i] = '0;

        // reset state
        #20;
        chk("rst_rdy",   {31'd0, in_ready}, 32'd0);
        chk("rst_count", {29'd0, count},    32'd0);
        chk("rst_rw",    {31'd0, RegWrite}, 32'd0);
        chk("rst_hit1",  {31'd0, hit1},     32'd0);
        chk("rst_byp1",  {16'd0, byp1},     32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rel_rdy", {31'd0, in_ready}, 32'd1);

        // single write, one-cycle latency
        push(4'd4, 16'h4444, 1'b1, 1'b0, 16'h0);
        chk("s_count", {29'd0, count},    32'd1);
        chk("s_wa",    {28'd0, WA1},      32'd4);
        chk("s_wd",    {16'd0, WD1},      32'h4444);
        chk("s_rw",    {31'd0, RegWrite}, 32'd1);
        tick();
        chk("s_count0", {29'd0, count}, 32'd0);
        chk("s_rf4",    {16'd0, rf[4]}, 32'h4444);

        // fill under stall, then drain in order
        wb_stall = 1'b1;
        for (int i = 1; i <= 4; i++)
            push(4'(i), 16'h1000 + 16'(i), 1'b1, 1'b0, 16'h0);
        chk("f_count", {29'd0, count},    32'd4);
        chk("f_rdy",   {31'd0, in_ready}, 32'd0);
        chk("f_rw",    {31'd0, RegWrite}, 32'd0);
        chk("f_wa",    {28'd0, WA1},      32'd1);
        chk("f_wd",    {16'd0, WD1},      32'h1001);
        wb_stall = 1'b0;
        #1;
        chk("f_rdy_same", {31'd0, in_ready}, 32'd0);
        chk("f_rw_on",    {31'd0, RegWrite}, 32'd1);
        tick();
        chk("f_rdy_next", {31'd0, in_ready}, 32'd1);
        chk("f_count3",   {29'd0, count},    32'd3);
        tick();
        tick();
        tick();
        chk("f_count0", {29'd0, count},    32'd0);
        chk("f_sb",     32'(sb.size()),    32'd0);

        // bypass picks youngest match
        wb_stall = 1'b1;
        push(4'd5, 16'h5555, 1'b1, 1'b0, 16'h0);
        push(4'd5, 16'hAAAA, 1'b1, 1'b0, 16'h0);
        RA1 = 4'd5;
        RA2 = 4'd6;
        #1;
        chk("b_hit1", {31'd0, hit1}, 32'd1);
        chk("b_byp1", {16'd0, byp1}, 32'hAAAA);
        chk("b_hit2", {31'd0, hit2}, 32'd0);
        chk("b_byp2", {16'd0, byp2}, 32'd0);
        wb_stall = 1'b0;
        #1;
        tick();
        chk("b_hit1_pop", {31'd0, hit1}, 32'd1);
        chk("b_byp1_pop", {16'd0, byp1}, 32'hAAAA);
        tick();
        chk("b_hit1_gone", {31'd0, hit1}, 32'd0);
        chk("b_count0",    {29'd0, count}, 32'd0);

        // R0 path and R0-only entry
        wb_stall = 1'b1;
        push(4'd0, 16'h1111, 1'b1, 1'b1, 16'h0001);
        RA1 = 4'd0;
        RA2 = 4'd0;
        #1;
        chk("r_hit1", {31'd0, hit1}, 32'd1);
        chk("r_byp1", {16'd0, byp1}, 32'h0001);
        push(4'd7, 16'h7777, 1'b0, 1'b1, 16'h0707);
        RA2 = 4'd7;
        #1;
        chk("r_byp1_y", {16'd0, byp1}, 32'h0707);
        chk("r_hit2",   {31'd0, hit2}, 32'd0);
        chk("r_byp2",   {16'd0, byp2}, 32'd0);
        wb_stall = 1'b0;
        #1;
        chk("r_r0w", {31'd0, R0W},      32'd1);
        chk("r_r0d", {16'd0, R0D},      32'h0001);
        chk("r_rw",  {31'd0, RegWrite}, 32'd1);
        tick();
        tick();
        chk("r_count0", {29'd0, count}, 32'd0);

        // alternating null/real entries with simultaneous drain, pointers wrap
        for (int i = 0; i < 9; i++) begin
            if (i % 2 == 1)
                push(4'(i), 16'hB000 + 16'(i), 1'b1, 1'b0, 16'h0);
            else
                push(4'(i), 16'hDEAD, 1'b0, 1'b0, 16'h0);
            chk("w_count", {29'd0, count}, (i % 2 == 1) ? 32'd1 : 32'd0);
        end
        tick();
        chk("w_count0", {29'd0, count}, 32'd0);
        chk("w_sb",     32'(sb.size()), 32'd0);
        chk("w_rf7",    {16'd0, rf[7]}, 32'hB007);

        // reset with entries pending
        wb_stall = 1'b1;
        push(4'd10, 16'hC00A, 1'b1, 1'b0, 16'h0);
        push(4'd11, 16'hC00B, 1'b1, 1'b0, 16'h0);
        push(4'd12, 16'hC00C, 1'b1, 1'b1, 16'hC0C0);
        RA1 = 4'd10;
        #1;
        chk("m_hit1", {31'd0, hit1}, 32'd1);
        rst = 1'b0;
        sb.delete();
        #1;
        chk("m_count", {29'd0, count},    32'd0);
        chk("m_rdy",   {31'd0, in_ready}, 32'd0);
        chk("m_rw",    {31'd0, RegWrite}, 32'd0);
        chk("m_r0w",   {31'd0, R0W},      32'd0);
        chk("m_wa",    {28'd0, WA1},      32'd0);
        chk("m_hit1r", {31'd0, hit1},     32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        wb_stall = 1'b0;
        tick();
        tick();
        chk("m_count_after", {29'd0, count}, 32'd0);
        chk("m_rf10",        {16'd0, rf[10]}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
